// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store opcodes, FSM state and access-size encodings for the data memory controller.
// The UART TX port is compiled in only when DMEM_UART_EN is defined.
package data_mem_ctrl_pkg;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic {
        DMEM_ST_IDLE,
        DMEM_ST_UART_WAIT
    } dmem_state_t;

    typedef enum logic [1:0] {
        DMEM_SZ_B,
        DMEM_SZ_H,
        DMEM_SZ_W,
        DMEM_SZ_NONE
    } dmem_size_t;

    typedef struct packed {
        logic       load;
        logic       store;
        logic       sgn;
        dmem_size_t size;
    } dmem_op_t;

    function automatic dmem_op_t decode_op(input logic [5:0] code);
        dmem_op_t op;
        op.load  = 1'b0;
        op.store = 1'b0;
        op.sgn   = 1'b0;
        op.size  = DMEM_SZ_NONE;
        case (code)
            ALU_LB:  begin op.load  = 1'b1; op.sgn = 1'b1; op.size = DMEM_SZ_B; end
            ALU_LH:  begin op.load  = 1'b1; op.sgn = 1'b1; op.size = DMEM_SZ_H; end
            ALU_LW:  begin op.load  = 1'b1; op.size = DMEM_SZ_W; end
            ALU_LBU: begin op.load  = 1'b1; op.size = DMEM_SZ_B; end
            ALU_LHU: begin op.load  = 1'b1; op.size = DMEM_SZ_H; end
            ALU_SB:  begin op.store = 1'b1; op.size = DMEM_SZ_B; end
            ALU_SH:  begin op.store = 1'b1; op.size = DMEM_SZ_H; end
            ALU_SW:  begin op.store = 1'b1; op.size = DMEM_SZ_W; end
            default: ;
        endcase
        return op;
    endfunction

    function automatic logic is_aligned(input dmem_size_t size, input logic [1:0] lo);
        case (size)
            DMEM_SZ_H: return (lo[0] == 1'b0);
            DMEM_SZ_W: return (lo == 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous-write, registered-read RAM.
// Only the read register is reset; the array contents are not.
module dmem_bank #(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
    end

    // rdata only moves on a load so the extended result stays stable until the next one
    always_ff @(posedge clk) begin
        if (!rst)
            rdata <= 8'h00;
        else if (re)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store data memory: four byte-lane banks, alignment check, sign/zero extension.
// Define DMEM_UART_EN to add a memory-mapped UART TX register at UART_ADDR.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] UART_ADDR  = 32'hf6fff070
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic        rsp_valid,
    output logic [31:0] r_data,
    output logic        misalign_err
`ifdef DMEM_UART_EN
    ,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
`endif
);

    dmem_state_t           state;
    dmem_op_t              dec;
    logic                  accept, aligned, uart_hit, tx_busy, wr_en, rd_en;
    logic [3:0]            be;
    logic [31:0]           wlane, rword;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  vld_p1, mis_p1, sgn_p1, uart_sel_p1, uart_stat_p1;
    dmem_size_t            size_p1;
    logic [1:0]            lane_p1;

    function automatic logic [31:0] extend(input logic [31:0] word, input dmem_size_t size,
                                           input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            DMEM_SZ_B: return {{24{sgn & b[7]}}, b};
            DMEM_SZ_H: return {{16{sgn & h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    assign req_ready = (state == DMEM_ST_IDLE);
    assign accept    = req_valid & req_ready & rst;
    assign dec       = decode_op(alucode);
    assign aligned   = is_aligned(dec.size, addr[1:0]);
    assign widx      = addr[DEPTH_LOG2+1:2];

`ifdef DMEM_UART_EN
    assign uart_hit = (addr == UART_ADDR);
    assign tx_busy  = uart_tx_valid;
`else
    logic unused_cfg;
    assign uart_hit   = 1'b0;
    assign tx_busy    = 1'b0;
    assign unused_cfg = ^{UART_ADDR, addr[31:DEPTH_LOG2+2]};
`endif

    assign wr_en = accept & dec.store & aligned & ~uart_hit;
    assign rd_en = accept & dec.load & aligned & ~uart_hit;

    // Replicating the low byte/half puts store data on every lane; be picks the live ones
    always_comb begin
        be    = 4'b0000;
        wlane = w_data;
        case (dec.size)
            DMEM_SZ_B: begin be = 4'b0001 << addr[1:0];         wlane = {4{w_data[7:0]}};  end
            DMEM_SZ_H: begin be = addr[1] ? 4'b1100 : 4'b0011; wlane = {2{w_data[15:0]}}; end
            DMEM_SZ_W: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        dmem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en & be[g]),
            .re    (rd_en),
            .idx   (widx),
            .wdata (wlane[8*g +: 8]),
            .rdata (rword[8*g +: 8])
        );
    end

    // ---- p1: response stage, one cycle after acceptance ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1       <= 1'b0;
            mis_p1       <= 1'b0;
            size_p1      <= DMEM_SZ_W;
            sgn_p1       <= 1'b0;
            lane_p1      <= 2'b00;
            uart_sel_p1  <= 1'b0;
            uart_stat_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept & dec.load & aligned;
            mis_p1 <= accept & (dec.load | dec.store) & ~aligned;
            if (accept & dec.load & aligned) begin
                size_p1      <= dec.size;
                sgn_p1       <= dec.sgn;
                lane_p1      <= addr[1:0];
                uart_sel_p1  <= uart_hit;
                uart_stat_p1 <= ~tx_busy;
            end
        end
    end

    assign rsp_valid    = vld_p1;
    assign misalign_err = mis_p1;
    assign r_data       = uart_sel_p1 ? {31'b0, uart_stat_p1}
                                      : extend(rword, size_p1, sgn_p1, lane_p1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DMEM_ST_IDLE;
`ifdef DMEM_UART_EN
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
`endif
        end else begin
`ifdef DMEM_UART_EN
            case (state)
                DMEM_ST_IDLE:
                    if (accept && dec.store && aligned && uart_hit) begin
                        state         <= DMEM_ST_UART_WAIT;
                        uart_tx_valid <= 1'b1;
                        uart_tx_data  <= w_data[7:0];
                    end
                DMEM_ST_UART_WAIT:
                    if (uart_tx_valid && uart_tx_ready) begin
                        state         <= DMEM_ST_IDLE;
                        uart_tx_valid <= 1'b0;
                    end
                default: state <= DMEM_ST_IDLE;
            endcase
`else
            state <= DMEM_ST_IDLE;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed literal cases plus randomized traffic against a byte-array model.
// UART cases are compiled in when DMEM_UART_EN is defined.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int          DL    = 10;
    localparam logic [31:0] UADDR = 32'hf6fff070;
    localparam logic [31:0] AMASK = (32'd1 << (DL + 2)) - 32'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  alucode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] w_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] r_data;
    logic        misalign_err;
`ifdef DMEM_UART_EN
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    byte unsigned model_mem [int];
    logic        exp_rsp = 1'b0, exp_mis = 1'b0, exp_known = 1'b1, exp_busy = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [7:0]  exp_txd = 8'd0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_LOG2(DL), .UART_ADDR(UADDR)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .alucode       (alucode),
        .addr          (addr),
        .w_data        (w_data),
        .rsp_valid     (rsp_valid),
        .r_data        (r_data),
        .misalign_err  (misalign_err)
`ifdef DMEM_UART_EN
        ,
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: checks what the previous edge should have produced, then predicts the next edge
    int          m_n, m_idx;
    bit          m_ld, m_st, m_sg, m_acc, m_uhit;
    logic [31:0] m_v;

    always @(negedge clk) begin
        if (chk_en) begin
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("misalign_err", 32'(misalign_err), 32'(exp_mis));
            if (exp_known) check("r_data", r_data, exp_rdata);
            check("req_ready", 32'(req_ready), 32'(!exp_busy));
`ifdef DMEM_UART_EN
            check("uart_tx_valid", 32'(uart_tx_valid), 32'(exp_busy));
            check("uart_tx_data", 32'(uart_tx_data), 32'(exp_txd));
`endif
        end
        exp_rsp = 1'b0;
        exp_mis = 1'b0;
        if (!rst) begin
            exp_rdata = 32'd0;
            exp_known = 1'b1;
            exp_busy  = 1'b0;
            exp_txd   = 8'd0;
        end else begin
            m_acc = req_valid && !exp_busy;
`ifdef DMEM_UART_EN
            if (exp_busy && uart_tx_ready) exp_busy = 1'b0;
            m_uhit = (addr == UADDR);
`else
            m_uhit = 1'b0;
`endif
            m_ld = 0; m_st = 0; m_sg = 0; m_n = 0;
            case (alucode)
                ALU_LB:  begin m_ld = 1; m_sg = 1; m_n = 1; end
                ALU_LH:  begin m_ld = 1; m_sg = 1; m_n = 2; end
                ALU_LW:  begin m_ld = 1; m_n = 4; end
                ALU_LBU: begin m_ld = 1; m_n = 1; end
                ALU_LHU: begin m_ld = 1; m_n = 2; end
                ALU_SB:  begin m_st = 1; m_n = 1; end
                ALU_SH:  begin m_st = 1; m_n = 2; end
                ALU_SW:  begin m_st = 1; m_n = 4; end
                default: m_n = 0;
            endcase
            if (m_acc && m_n != 0) begin
                if (addr % m_n != 0) begin
                    exp_mis = 1'b1;
                end else if (m_uhit) begin
                    if (m_st) begin
                        exp_busy = 1'b1;
                        exp_txd  = w_data[7:0];
                    end else begin
                        exp_rsp   = 1'b1;
                        exp_rdata = 32'd1;
                        exp_known = 1'b1;
                    end
                end else if (m_st) begin
                    for (int i = 0; i < m_n; i++)
                        model_mem[int'(addr & AMASK) + i] = w_data[8*i +: 8];
                end else begin
                    m_v = 32'd0;
                    exp_known = 1'b1;
                    for (int i = 0; i < m_n; i++) begin
                        m_idx = int'(addr & AMASK) + i;
                        if (model_mem.exists(m_idx)) m_v[8*i +: 8] = model_mem[m_idx];
                        else exp_known = 1'b0;
                    end
                    exp_rsp = 1'b1;
                    if (m_sg && m_n == 1)      exp_rdata = $signed(m_v[7:0]);
                    else if (m_sg && m_n == 2) exp_rdata = $signed(m_v[15:0]);
                    else                       exp_rdata = m_v;
                end
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1 with this request's response visible
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; alucode = op; addr = a; w_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0; alucode = 6'd0;
    endtask

    task automatic load_chk(input string nm, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] exp);
        drive(op, a, 32'd0);
        check({nm, " data"}, r_data, exp);
        check({nm, " vld"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic mis_chk(input string nm, input logic [5:0] op, input logic [31:0] a);
        drive(op, a, 32'h1111_1111);
        check({nm, " err"}, 32'(misalign_err), 32'd1);
        check({nm, " vld"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [5:0] op_tab [9];

    initial begin
        op_tab = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW, 6'd63};
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset r_data", r_data, 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;

        drive(ALU_SW, 32'h100, 32'h1234_5678);
        load_chk("lw 0x100", ALU_LW, 32'h100, 32'h1234_5678);
        drive(ALU_SB, 32'h103, 32'h0000_0080);
        load_chk("lb 0x103", ALU_LB, 32'h103, 32'hffff_ff80);
        load_chk("lbu 0x103", ALU_LBU, 32'h103, 32'h0000_0080);
        drive(ALU_SH, 32'h102, 32'h0000_beef);
        load_chk("lw after sh", ALU_LW, 32'h100, 32'hbeef_5678);
        load_chk("lh 0x102", ALU_LH, 32'h102, 32'hffff_beef);
        load_chk("lhu 0x102", ALU_LHU, 32'h102, 32'h0000_beef);
        drive(ALU_SW, 32'h200, 32'hcafe_f00d);
        mis_chk("lw 0x101", ALU_LW, 32'h101);
        mis_chk("sh 0x203", ALU_SH, 32'h203);
        load_chk("mem kept 0x100", ALU_LW, 32'h100, 32'hbeef_5678);
        load_chk("mem kept 0x200", ALU_LW, 32'h200, 32'hcafe_f00d);
        drive(6'd63, 32'h100, 32'h0);
        check("noop vld", 32'(rsp_valid), 32'd0);
        check("noop err", 32'(misalign_err), 32'd0);
        check("noop held r_data", r_data, 32'hcafe_f00d);
        drive(ALU_SW, 32'd1 << (DL + 2), 32'ha5a5_a5a5);
        load_chk("alias lw 0x0", ALU_LW, 32'h0, 32'ha5a5_a5a5);

        for (int w = 0; w < 16; w++) drive(ALU_SW, 32'(w * 4), $urandom);

        for (int it = 0; it < 600; it++) begin
            rst       = (it == 300) ? 1'b0 : 1'b1;
            req_valid = ($urandom_range(0, 7) != 0);
            alucode   = op_tab[$urandom_range(0, 8)];
            addr      = ($urandom & ~AMASK) | (32'($urandom_range(0, 15)) << 2)
                        | 32'($urandom_range(0, 3));
            w_data    = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;

`ifdef DMEM_UART_EN
        uart_tx_ready = 1'b0;
        drive(ALU_SB, UADDR, 32'h0000_0041);
        for (int c = 0; c < 3; c++) begin
            check("uart wait ready", 32'(req_ready), 32'd0);
            check("uart wait valid", 32'(uart_tx_valid), 32'd1);
            check("uart wait data", 32'(uart_tx_data), 32'h41);
            @(posedge clk); #1;
        end
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
        check("uart done ready", 32'(req_ready), 32'd1);
        check("uart done valid", 32'(uart_tx_valid), 32'd0);
        load_chk("uart status", ALU_LW, UADDR, 32'd1);
        uart_tx_ready = 1'b0;
        drive(ALU_SB, UADDR, 32'h0000_0042);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("uart reset valid", 32'(uart_tx_valid), 32'd0);
        check("uart reset ready", 32'(req_ready), 32'd1);
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
